// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC instruction fetch sequencer.
package agc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    TP,
    FAULT
  } fetch_state_t;

  localparam int WORD_W = 15;
  localparam int MEM_W = 16;
  localparam logic [11:0] RESET_PC = 12'o4000;
  localparam int TP_DECODE = 4;

endpackage

// File: rtl/agc_tp_counter.sv
// Timing pulse counter: loads 1 on start, steps 1..NUM_TP while enabled, then returns to 0.
module agc_tp_counter
  import agc_pkg::*;
#(
  parameter int NUM_TP = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       en,
  output logic [3:0] tp_num,
  output logic       tp4,
  output logic       last_tp
);

  assign tp4 = (tp_num == 4'(TP_DECODE));
  assign last_tp = (tp_num == 4'(NUM_TP));

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_num <= '0;
    end else if (start) begin
      tp_num <= 4'd1;
    end else if (en) begin
      tp_num <= last_tp ? 4'd0 : tp_num + 4'd1;
    end
  end

endmodule

// File: rtl/agc_fetch_sequencer.sv
// AGC fetch sequencer: reads one parity-checked word per instruction and steps the timing pulses.
module agc_fetch_sequencer #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(agc_pkg::RESET_PC),
  parameter int                NUM_TP   = 12,
  parameter int                TIMEOUT  = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd,
  input  logic                        mem_ready,
  input  logic [agc_pkg::MEM_W-1:0]   mem_data,
  output logic [agc_pkg::WORD_W-1:0]  instr,
  output logic                        instr_valid,
  output logic [3:0]                  tp_num,
  output logic                        tp4,
  input  logic                        jump,
  input  logic [ADDR_W-1:0]           jump_addr,
  output logic [ADDR_W-1:0]           pc,
  output logic                        parity_err,
  output logic                        bus_timeout,
  output logic                        busy
);
  import agc_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The wait counter holds k-1 during the k-th WAIT cycle, so this marks the last allowed cycle.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  fetch_state_t     state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             parity_ok;
  logic             capture;
  logic             par_fault;
  logic             timeout_fault;
  logic             last_tp;

  assign parity_ok     = ^mem_data;
  assign capture       = (state == WAIT) && mem_ready && parity_ok;
  assign par_fault     = (state == WAIT) && mem_ready && !parity_ok;
  assign timeout_fault = (state == WAIT) && !mem_ready && (wait_cnt == LAST_WAIT);

  assign mem_addr    = pc;
  assign mem_rd      = (state == ADDR);
  assign instr_valid = (state == TP);
  assign busy        = (state != IDLE) && (state != FAULT);

  agc_tp_counter #(
    .NUM_TP(NUM_TP)
  ) u_tp_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (capture),
    .en     (state == TP),
    .tp_num (tp_num),
    .tp4    (tp4),
    .last_tp(last_tp)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = ADDR;
      ADDR:    next_state = WAIT;
      WAIT: begin
        if (capture) next_state = TP;
        else if (par_fault || timeout_fault) next_state = FAULT;
      end
      TP:      if (last_tp) next_state = run ? ADDR : IDLE;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pc          <= RESET_PC;
      instr       <= '0;
      parity_err  <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ADDR) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (capture) instr <= mem_data[MEM_W-1:1];
      // jump is only meaningful in the final timing pulse; the pc wraps naturally.
      if ((state == TP) && last_tp) pc <= jump ? jump_addr : pc + 1'b1;
      if (par_fault) parity_err <= 1'b1;
      if (timeout_fault) bus_timeout <= 1'b1;
    end
  end

endmodule
